rgb565_capture: RTL and testbench
=================================

// Module: rgb565_capture
// PURPOSE
//  Front-end capture stage of the frame-buffer pixel path, directly upstream of the RGB-to-grey converter.
//  Accepts a camera-style byte stream qualified by vsync/href/byte strobe.
//  Assembles byte pairs into RGB565 and expands each channel to 8 bits.
//  Emits one registered pixel per pair on red/green/blue with a valid strobe and x/y coordinates.
//  Checks line and frame geometry and flags short or long lines and frames.
// PARAMETERS
//  H_ACTIVE    640  pixels per line (byte pairs per href-high period)
//  V_ACTIVE    480  lines per frame
//  X_W         10   width of pix_x; must hold H_ACTIVE-1
//  Y_W         9    width of pix_y; must hold V_ACTIVE-1
//  HI_FIRST    1    1: first byte of a pair is {R5,G6[5:3]}; 0: byte order swapped
// PORTS
//  clk          in   1    single clock; all inputs are synchronous to it
//  rst          in   1    synchronous, active-high reset
//  cam_vsync    in   1    frame sync, high during vertical blanking
//  cam_href     in   1    line valid, high while a line's bytes are delivered
//  cam_de       in   1    byte strobe; cam_data is valid when cam_href & cam_de
//  cam_data     in   8    pixel byte
//  red          out  8    expanded red, held between pixels
//  green        out  8    expanded green, held between pixels
//  blue         out  8    expanded blue, held between pixels
//  pix_valid    out  1    1-cycle pulse: red/green/blue/pix_x/pix_y are valid
//  pix_x        out  X_W  column of the current pixel
//  pix_y        out  Y_W  row of the current pixel
//  frame_start  out  1    1-cycle pulse at the start of the first active line of a frame
//  frame_done   out  1    1-cycle pulse: frame ended with exactly V_ACTIVE good lines
//  line_err     out  1    1-cycle pulse: line ended with the wrong count or an odd byte count
//  frame_err    out  1    1-cycle pulse: frame ended with line count != V_ACTIVE
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> S_SYNC; phase, x and y counters cleared. A reset mid-line or mid-frame abandons it.
//  S_SYNC: ignore all data until cam_vsync==1, then -> S_VBLANK. No partial frame is ever captured after reset.
//  S_VBLANK: on cam_vsync==0 -> S_ACTIVE; y=0, x=0, phase=0.
//  S_ACTIVE:
//   - Each byte (href & de): phase 0 latches the byte; phase 1 forms the 16-bit word, with byte order per HI_FIRST.
//   - Expansion: R8={R5,R5[4:2]}; G8={G6,G6[5:4]}; B8={B5,B5[4:2]}.
//   - Output timing: red/green/blue/pix_x/pix_y and pix_valid are registered, 1 cycle after the phase-1 byte cycle.
//   - After each pixel, x increments.
//   - Overflow pixels: when x>=H_ACTIVE or y>=V_ACTIVE, the pixel is dropped (no pix_valid); x saturates at H_ACTIVE.
//   - frame_start: pulses together with pix_valid of pixel (0,0).
//   - href falling edge (href 1->0, sampled against a registered href):
//     * line_err pulses if x!=H_ACTIVE or phase==1; a dangling odd byte is discarded.
//     * y increments, saturating at V_ACTIVE; x and phase clear.
//   - cam_vsync==1 -> S_VBLANK. The next cycle pulses frame_done if y==V_ACTIVE, else frame_err.
//   - vsync rising while href==1: line_err and the frame-end pulse occur in the same cycle; the line still counts.
//  Only one of frame_done and frame_err ever pulses per frame. Pulses never last more than 1 cycle.
//  red/green/blue hold their last value when pix_valid==0.
//  Bytes with cam_de==0 or cam_href==0 have no effect.
// TESTING
//  - rst=1 for 2 cycles mid-line -> all outputs 0; data is ignored until vsync 1->0 is seen again.
//  - Byte pairs F8,00 / 07,E0 / 00,1F (HI_FIRST=1) -> RGB FF,00,00 / 00,FF,00 / 00,00,FF. pix_valid arrives 1 cycle after the 2nd byte.
//  - Byte pair 84,10 -> RGB 84,82,84. Same pair with HI_FIRST=0 sent as 10,84 -> identical output.
//  - H_ACTIVE=4, V_ACTIVE=2: 2 lines of 8 bytes, then vsync -> 8 pix_valid with (x,y) = (0..3, 0..1).
//    frame_start with (0,0); frame_done 1 cycle after vsync rises; no errors.
//  - Line of 7 bytes (H_ACTIVE=4) -> 3 pixels, line_err on href fall.
//    Next line has x=0; 1-line frame -> frame_err, not frame_done.
//  - Line of 12 bytes with gaps of cam_de=0 (H_ACTIVE=4) -> 4 pixels only, x saturates at 4, line_err, y advances by 1.

Source files
------------

// File: rtl/rgb565_capture_if.sv
// Camera byte stream in, expanded RGB pixels and geometry status out.
interface rgb565_capture_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
);
  logic           cam_vsync;
  logic           cam_href;
  logic           cam_de;
  logic [7:0]     cam_data;
  logic [7:0]     red;
  logic [7:0]     green;
  logic [7:0]     blue;
  logic           pix_valid;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           frame_start;
  logic           frame_done;
  logic           line_err;
  logic           frame_err;

  modport master (
    output cam_vsync, cam_href, cam_de, cam_data,
    input  red, green, blue, pix_valid, pix_x, pix_y,
    input  frame_start, frame_done, line_err, frame_err
  );

  modport slave (
    input  cam_vsync, cam_href, cam_de, cam_data,
    output red, green, blue, pix_valid, pix_x, pix_y,
    output frame_start, frame_done, line_err, frame_err
  );
endinterface

// File: rtl/rgb565_capture.sv
// Camera byte-pair capture: assembles RGB565, expands to RGB888 and tracks
// line/frame geometry, flagging short or long lines and frames.
module rgb565_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter bit          HI_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst,
  rgb565_capture_if.slave bus
);

  localparam int unsigned XC_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned YC_W = $clog2(V_ACTIVE + 1);
  localparam logic [XC_W-1:0] H_MAX = XC_W'(H_ACTIVE);
  localparam logic [YC_W-1:0] V_MAX = YC_W'(V_ACTIVE);

  typedef enum logic [1:0] {StSync, StVblank, StActive} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic            href_q, href_d;
  logic            x_ovf_q, x_ovf_d;
  logic            y_ovf_q, y_ovf_d;
  logic [7:0]      byte_q, byte_d;
  logic [XC_W-1:0] x_q, x_d;
  logic [YC_W-1:0] y_q, y_d;

  logic [7:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            pix_valid_q, pix_valid_d;
  logic [X_W-1:0]  pix_x_q, pix_x_d;
  logic [Y_W-1:0]  pix_y_q, pix_y_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            line_err_q, line_err_d;
  logic            frame_err_q, frame_err_d;

  logic            byte_ok;
  logic            line_end;
  logic [15:0]     word;
  logic [YC_W-1:0] y_inc, y_end;
  logic            y_ovf_end;

  always_comb begin
    byte_ok   = bus.cam_href & bus.cam_de;
    word      = HI_FIRST ? {byte_q, bus.cam_data} : {bus.cam_data, byte_q};
    // A line closes on href falling, or when vsync cuts it short.
    line_end  = (state_q == StActive) & href_q & (~bus.cam_href | bus.cam_vsync);
    y_inc     = (y_q == V_MAX) ? y_q : y_q + YC_W'(1);
    y_end     = line_end ? y_inc : y_q;
    y_ovf_end = y_ovf_q | (line_end & (y_q == V_MAX));
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    href_d        = 1'b0;
    x_ovf_d       = x_ovf_q;
    y_ovf_d       = y_ovf_q;
    byte_d        = byte_q;
    x_d           = x_q;
    y_d           = y_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      StSync: begin
        if (bus.cam_vsync) state_d = StVblank;
      end
      StVblank: begin
        if (!bus.cam_vsync) begin
          state_d = StActive;
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          x_ovf_d = 1'b0;
          y_ovf_d = 1'b0;
        end
      end
      StActive: begin
        if (bus.cam_vsync) begin
          state_d      = StVblank;
          frame_done_d = (y_end == V_MAX) & ~y_ovf_end;
          frame_err_d  = ~((y_end == V_MAX) & ~y_ovf_end);
        end else begin
          href_d = bus.cam_href;
          if (byte_ok) begin
            if (!phase_q) begin
              byte_d  = bus.cam_data;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if ((x_q < H_MAX) && (y_q < V_MAX)) begin
                pix_valid_d   = 1'b1;
                red_d         = {word[15:11], word[15:13]};
                green_d       = {word[10:5], word[10:9]};
                blue_d        = {word[4:0], word[4:2]};
                pix_x_d       = X_W'(x_q);
                pix_y_d       = Y_W'(y_q);
                frame_start_d = (x_q == '0) && (y_q == '0);
              end
              if (x_q < H_MAX) x_d = x_q + XC_W'(1);
              else             x_ovf_d = 1'b1;
            end
          end
        end
        if (line_end) begin
          line_err_d = (x_q != H_MAX) | phase_q | x_ovf_q |
                       (bus.cam_vsync & bus.cam_href);
          y_d        = y_inc;
          y_ovf_d    = y_ovf_end;
          x_d        = '0;
          phase_d    = 1'b0;
          x_ovf_d    = 1'b0;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSync;
      phase_q       <= 1'b0;
      href_q        <= 1'b0;
      x_ovf_q       <= 1'b0;
      y_ovf_q       <= 1'b0;
      byte_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      href_q        <= href_d;
      x_ovf_q       <= x_ovf_d;
      y_ovf_q       <= y_ovf_d;
      byte_q        <= byte_d;
      x_q           <= x_d;
      y_q           <= y_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.line_err    = line_err_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_rgb565_capture.sv
// Bench for rgb565_capture: two instances (both byte orders) on a shared stream,
// checked every cycle against expectations derived per line and per frame.
module tb_rgb565_capture;
  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rgb565_capture_if #(.X_W(2), .Y_W(1)) if1 ();
  rgb565_capture_if #(.X_W(2), .Y_W(1)) if0 ();

  rgb565_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(2), .Y_W(1), .HI_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  rgb565_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(2), .Y_W(1), .HI_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  typedef struct {
    bit v, fs, fd, le, fe, rs;
    int x, y;
    bit [23:0] c1, c0;
  } exp_t;

  exp_t exp_q [int];
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit active = 1'b0;
  bit seen_vs = 1'b0;
  int lines = 0;
  logic [7:0] line_q [$];
  logic [23:0] log1 [$];
  logic [23:0] log0 [$];
  int logxy [$];
  logic [23:0] h1 = '0;
  logic [23:0] h0 = '0;

  // RGB565 -> RGB888 by bit replication, in plain arithmetic.
  function automatic bit [23:0] expand(input bit [15:0] w);
    int r, g, b;
    r = int'(w) >> 11;
    g = (int'(w) >> 5) & 63;
    b = int'(w) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  function automatic exp_t exp_at(input int k);
    exp_t e;
    e = '{default: 0};
    if (exp_q.exists(k)) e = exp_q[k];
    return e;
  endfunction

  task automatic check(input string n, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", n, cyc, act, expv);
    end
  endtask

  task automatic compare_cycle();
    exp_t e;
    e = exp_at(cyc);
    if (exp_q.exists(cyc)) exp_q.delete(cyc);
    if (e.rs) begin h1 = '0; h0 = '0; end
    if (e.v)  begin h1 = e.c1; h0 = e.c0; end
    check("pix_valid1", int'(if1.pix_valid), int'(e.v));
    check("pix_valid0", int'(if0.pix_valid), int'(e.v));
    check("frame_start1", int'(if1.frame_start), int'(e.fs));
    check("frame_start0", int'(if0.frame_start), int'(e.fs));
    check("frame_done", int'(if1.frame_done), int'(e.fd));
    check("frame_err", int'(if1.frame_err), int'(e.fe));
    check("line_err", int'(if1.line_err), int'(e.le));
    check("errs0", int'({if0.frame_done, if0.frame_err, if0.line_err}),
          int'({e.fd, e.fe, e.le}));
    check("rgb1", int'({if1.red, if1.green, if1.blue}), int'(h1));
    check("rgb0", int'({if0.red, if0.green, if0.blue}), int'(h0));
    if (e.v) begin
      check("pix_x", int'(if1.pix_x), e.x);
      check("pix_y", int'(if1.pix_y), e.y);
      check("pix_xy0", int'({if0.pix_x, if0.pix_y}), int'({if1.pix_x, if1.pix_y}));
    end
    if (if1.pix_valid) begin
      log1.push_back({if1.red, if1.green, if1.blue});
      logxy.push_back(int'(if1.pix_x) * 16 + int'(if1.pix_y));
    end
    if (if0.pix_valid) log0.push_back({if0.red, if0.green, if0.blue});
  endtask

  always @(negedge clk) if (chk_en) compare_cycle();

  task automatic step(input bit r, input bit vs, input bit hr, input bit de,
                      input logic [7:0] d, output int k);
    rst = r;
    if1.cam_vsync = vs; if1.cam_href = hr; if1.cam_de = de; if1.cam_data = d;
    if0.cam_vsync = vs; if0.cam_href = hr; if0.cam_de = de; if0.cam_data = d;
    k = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rbyte();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    int k;
    exp_t e;
    repeat (n) begin
      step(1'b1, 1'b0, 1'b1, rbit(), rbyte(), k);
      e = exp_at(k); e.rs = 1'b1; exp_q[k] = e;
    end
    active = 1'b0; seen_vs = 1'b0; lines = 0;
  endtask

  task automatic end_frame();
    int k;
    exp_t e;
    step(1'b0, 1'b1, 1'b0, rbit(), rbyte(), k);
    if (active) begin
      e = exp_at(k);
      if (lines == V) e.fd = 1'b1; else e.fe = 1'b1;
      exp_q[k] = e;
    end
    active = 1'b0; seen_vs = 1'b1;
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, rbit(), rbit(), rbyte(), k);
  endtask

  task automatic start_frame();
    int k;
    step(1'b0, 1'b0, 1'b0, rbit(), rbyte(), k);
    if (seen_vs) begin active = 1'b1; lines = 0; seen_vs = 1'b0; end
  endtask

  // Sends line_q with random de gaps; pixel p of line li is due one cycle after
  // its second byte when p<H and li<V.
  task automatic send_line(input bit vs_end, input int rst_at);
    int k, li, n;
    exp_t e;
    logic [7:0] prev, b;
    li = lines; n = line_q.size(); prev = '0;
    for (int j = 0; j < n; j++) begin
      if (j == rst_at) do_reset(2);
      while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b1, 1'b0, rbyte(), k);
      b = line_q[j];
      step(1'b0, 1'b0, 1'b1, 1'b1, b, k);
      if ((j % 2 == 1) && active && (j / 2 < H) && (li < V)) begin
        e = exp_at(k);
        e.v = 1'b1; e.x = j / 2; e.y = li;
        e.c1 = expand({prev, b}); e.c0 = expand({b, prev});
        e.fs = (j == 1) && (li == 0);
        exp_q[k] = e;
      end
      prev = b;
    end
    if (vs_end) begin
      step(1'b0, 1'b1, 1'b1, rbit(), rbyte(), k);
      if (active) begin
        lines++;
        e = exp_at(k); e.le = 1'b1;
        if (lines == V) e.fd = 1'b1; else e.fe = 1'b1;
        exp_q[k] = e;
      end
      active = 1'b0; seen_vs = 1'b1;
      step(1'b0, 1'b1, 1'b0, rbit(), rbyte(), k);
    end else begin
      step(1'b0, 1'b0, 1'b0, rbit(), rbyte(), k);
      if (active) begin
        e = exp_at(k); e.le = (n != 2 * H); exp_q[k] = e;
        lines++;
      end
    end
    repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0, rbit(), rbyte(), k);
  endtask

  task automatic rand_line(input int n);
    line_q.delete();
    repeat (n) line_q.push_back(rbyte());
  endtask

  initial begin
    int k, nl, n, sel;
    bit vse;
    if1.cam_vsync = 1'b0; if1.cam_href = 1'b0; if1.cam_de = 1'b0; if1.cam_data = '0;
    if0.cam_vsync = 1'b0; if0.cam_href = 1'b0; if0.cam_de = 1'b0; if0.cam_data = '0;
    chk_en = 1'b1;
    do_reset(2);

    // No vsync seen since reset: this line must be ignored.
    rand_line(8); send_line(1'b0, -1);
    end_frame(); start_frame();

    // Directed colours, then HI_FIRST=0 pin with swapped bytes.
    line_q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h84, 8'h10};
    send_line(1'b0, -1);
    line_q = '{8'h10, 8'h84, 8'h10, 8'h84, 8'h10, 8'h84, 8'h10, 8'h84};
    send_line(1'b0, -1);
    end_frame();
    check("lit_count", log1.size(), 8);
    check("lit_red", int'(log1[0]), 24'hFF0000);
    check("lit_green", int'(log1[1]), 24'h00FF00);
    check("lit_blue", int'(log1[2]), 24'h0000FF);
    check("lit_8410", int'(log1[3]), 24'h848284);
    check("lit_swap", int'(log0[4]), 24'h848284);
    check("lit_xy_first", logxy[0], 0);
    check("lit_xy_last", logxy[7], 3 * 16 + 1);

    // Short odd line, then a 1-line frame.
    start_frame(); rand_line(7); send_line(1'b0, -1); end_frame();
    // Long line with gaps, then a good line.
    start_frame(); rand_line(12); send_line(1'b0, -1); rand_line(8); send_line(1'b0, -1);
    end_frame();
    // vsync rising while href is high on the last line.
    start_frame(); rand_line(8); send_line(1'b0, -1); rand_line(8); send_line(1'b1, -1);

    // Reset mid-line, line before vsync ignored, then a normal frame.
    start_frame(); rand_line(8); send_line(1'b0, 3);
    rand_line(8); send_line(1'b0, -1);
    end_frame(); start_frame();
    rand_line(8); send_line(1'b0, -1); rand_line(8); send_line(1'b0, -1); end_frame();

    for (int f = 0; f < 30; f++) begin
      start_frame();
      sel = $urandom_range(0, 9);
      nl = (sel < 6) ? V : (sel < 8) ? V - 1 : V + 1;
      vse = ($urandom_range(0, 6) == 0);
      for (int l = 0; l < nl; l++) begin
        sel = $urandom_range(0, 9);
        n = (sel < 7) ? 2 * H : (sel == 7) ? 2 * H - 1 : (sel == 8) ? 2 * H + 4 : 2;
        rand_line(n);
        send_line(vse && (l == nl - 1), -1);
      end
      if (!vse) end_frame();
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, k);
    check("pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
